tm1638_cmd_scheduler: RTL and testbench
=======================================

Name: tm1638_cmd_scheduler

Overview:
- Sequences all command traffic to the TM1638 SPI command engine.
- Arbitrates between two requesters:
  - display-RAM writes from the display/stimulus logic;
  - periodic key-scan reads driven by an internal timer.
- After reset it issues the display-control (brightness) command once.
- Returns the latest 32-bit key-scan result to the design.

Parameters:
- SCAN_PERIOD_CYCLES, 1000: clock cycles between key-scan requests (≥4).
- BRIGHTNESS, 7: 3-bit brightness level placed in the display-control command 0x88|BRIGHTNESS.
- READ_WIDTH, 32: key-scan read width in bits.

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  reset, asynchronous, active-high
- i_Disp_Valid  in  1  display write request
- i_Disp_Addr  in  4  display RAM address 0..15
- i_Disp_Data  in  8  display RAM byte
- o_Disp_Ready  out  1  one-cycle pulse: request accepted, addr/data latched
- o_Cmd_Valid  out  1  command offered to SPI engine
- o_Cmd_Kind  out  2  0=CMD1 (one byte), 1=CMD2 (two bytes), 2=READ (one byte, then READ_WIDTH bits in)
- o_Cmd_Byte0  out  8  first byte
- o_Cmd_Byte1  out  8  second byte (CMD2 only, else 0)
- i_Cmd_Ready  in  1  engine accepts command
- i_Cmd_Done  in  1  one-cycle pulse: engine finished command
- i_Read_Data  in  READ_WIDTH  read result, valid with i_Cmd_Done of a READ
- o_Keys  out  READ_WIDTH  last key-scan result
- o_Keys_Valid  out  1  one-cycle pulse when o_Keys updates

Behaviour:
- Reset values: o_Cmd_Valid=0, o_Cmd_Kind=0, o_Cmd_Byte0/1=0, o_Disp_Ready=0, o_Keys=0, o_Keys_Valid=0, scan timer=0, scan_pending=0, last_grant=SCAN, state=INIT.
- Reset asserted mid-operation: abort immediately to these values; after release the sequence restarts from INIT.
- Command handshake:
  - Command transfers on the rising edge where o_Cmd_Valid && i_Cmd_Ready.
  - o_Cmd_Valid and all command fields are held stable until that edge; o_Cmd_Valid deasserts the following cycle.
- Done handling:
  - The block waits in WAIT for i_Cmd_Done before issuing anything further.
  - i_Cmd_Done outside WAIT is ignored.
- Scan timer:
  - Free-running counter 0..SCAN_PERIOD_CYCLES-1.
  - On wrap, scan_pending is set.
  - A wrap while scan_pending is already set is lost; the timer keeps running.
- States:
  - INIT: offer CMD1 0x88|BRIGHTNESS → WAIT → IDLE.
  - IDLE arbitration:
    - if only scan_pending, go SCAN;
    - if only i_Disp_Valid, go MODE;
    - if both, grant the one not equal to last_grant (round-robin).
  - MODE:
    - on entry, pulse o_Disp_Ready and latch addr/data;
    - offer CMD1 0x44 (write, fixed address) → WAIT → WRITE.
  - WRITE: offer CMD2 byte0=0xC0|addr, byte1=data → WAIT → IDLE; last_grant=DISP.
  - SCAN:
    - clear scan_pending on entry;
    - offer READ 0x42 → WAIT;
    - on i_Cmd_Done capture i_Read_Data into o_Keys and pulse o_Keys_Valid the next cycle;
    - → IDLE; last_grant=SCAN.
- Latency: from IDLE with a request to o_Cmd_Valid high is 1 cycle. o_Disp_Ready rises in the same cycle as the MODE command's o_Cmd_Valid.
- i_Disp_Valid is sampled only in IDLE. The requester holds valid/addr/data until o_Disp_Ready.
- Address 16+ is impossible (4-bit port); no wrap logic needed.

Optional Feature:
- Macro: TM1638_CMD_SCHEDULER_DIAG_EN.
- When defined, adds two outputs:
  - o_Diag_State (3 bits, state encoding INIT=0, IDLE=1, MODE=2, WRITE=3, SCAN=4, WAIT=5);
  - o_Diag_Scan_Overruns (8 bits): saturating count of timer wraps lost while scan_pending was set; reset 0.
- When undefined, these ports and their logic are absent; functional behaviour is identical.

Test Plan:
- Reset release, i_Cmd_Ready=1, Done 3 cycles after each transfer, no requests → first command is CMD1 0x8F (BRIGHTNESS=7); then idle until scan timer wraps.
- Single display write addr=3 data=0x5A → CMD1 0x44, then CMD2 0xC3/0x5A; o_Disp_Ready pulses exactly once.
- Scan with SCAN_PERIOD_CYCLES=20, i_Read_Data=0x0000_8001 on Done → READ 0x42 issued; o_Keys=0x0000_8001 with a one-cycle o_Keys_Valid.
- Display valid held continuously with scan pending simultaneously → grants alternate SCAN, DISP, SCAN, DISP; neither requester is starved.
- i_Cmd_Ready held low 10 cycles → o_Cmd_Valid and fields stay constant throughout; a spurious i_Cmd_Done in IDLE causes no state change.
- i_Rst asserted in WAIT of a WRITE → outputs go to reset values asynchronously; after release CMD1 0x8F is reissued first (with DIAG_EN: o_Diag_State=0).

Source files
------------

// File: rtl/tm1638_cmd_scheduler.sv
// TM1638 command scheduler: brightness init, round-robin between display writes and timed key scans.
// Optional diagnostics (state, lost scan wraps) are enabled by defining TM1638_CMD_SCHEDULER_DIAG_EN.
module tm1638_cmd_scheduler #(
  parameter int unsigned SCAN_PERIOD_CYCLES = 1000,
  parameter int unsigned BRIGHTNESS         = 7,
  parameter int unsigned READ_WIDTH         = 32
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  input  logic                  i_Disp_Valid,
  input  logic [3:0]            i_Disp_Addr,
  input  logic [7:0]            i_Disp_Data,
  output logic                  o_Disp_Ready,
  output logic                  o_Cmd_Valid,
  output logic [1:0]            o_Cmd_Kind,
  output logic [7:0]            o_Cmd_Byte0,
  output logic [7:0]            o_Cmd_Byte1,
  input  logic                  i_Cmd_Ready,
  input  logic                  i_Cmd_Done,
  input  logic [READ_WIDTH-1:0] i_Read_Data,
  output logic [READ_WIDTH-1:0] o_Keys,
  output logic                  o_Keys_Valid
`ifdef TM1638_CMD_SCHEDULER_DIAG_EN
  ,
  output logic [2:0]            o_Diag_State,
  output logic [7:0]            o_Diag_Scan_Overruns
`endif
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_MODE  = 3'd2,
    S_WRITE = 3'd3,
    S_SCAN  = 3'd4,
    S_WAIT  = 3'd5
  } state_t;

  typedef enum logic {
    GRANT_DISP = 1'b0,
    GRANT_SCAN = 1'b1
  } grant_t;

  localparam logic [1:0] KIND_CMD1 = 2'd0;
  localparam logic [1:0] KIND_CMD2 = 2'd1;
  localparam logic [1:0] KIND_READ = 2'd2;

  localparam logic [7:0] CMD_DISP_CTRL = {5'b10001, BRIGHTNESS[2:0]};
  localparam logic [7:0] CMD_WRITE_FIX = 8'h44;
  localparam logic [7:0] CMD_READ_KEYS = 8'h42;

  localparam int unsigned       CNT_W    = $clog2(SCAN_PERIOD_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SCAN_PERIOD_CYCLES - 1);

  state_t                  state, state_nxt;
  state_t                  ret_state, ret_state_nxt;
  grant_t                  last_grant, last_grant_nxt;
  logic [3:0]              addr_q, addr_nxt;
  logic [7:0]              data_q, data_nxt;
  logic                    cmd_valid_nxt;
  logic [1:0]              cmd_kind_nxt;
  logic [7:0]              cmd_byte0_nxt, cmd_byte1_nxt;
  logic                    disp_ready_nxt;
  logic [READ_WIDTH-1:0]   keys_nxt;
  logic                    keys_valid_nxt;
  logic                    grant_scan;

  logic [CNT_W-1:0]        scan_cnt;
  logic                    scan_pending;
  logic                    scan_wrap;

  assign scan_wrap = (scan_cnt == CNT_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    ret_state_nxt  = ret_state;
    last_grant_nxt = last_grant;
    addr_nxt       = addr_q;
    data_nxt       = data_q;
    cmd_valid_nxt  = o_Cmd_Valid;
    cmd_kind_nxt   = o_Cmd_Kind;
    cmd_byte0_nxt  = o_Cmd_Byte0;
    cmd_byte1_nxt  = o_Cmd_Byte1;
    disp_ready_nxt = 1'b0;
    keys_nxt       = o_Keys;
    keys_valid_nxt = 1'b0;
    grant_scan     = 1'b0;

    unique case (state)
      S_INIT: begin
        if (o_Cmd_Valid && i_Cmd_Ready) begin
          cmd_valid_nxt = 1'b0;
          ret_state_nxt = S_IDLE;
          state_nxt     = S_WAIT;
        end else begin
          cmd_valid_nxt = 1'b1;
          cmd_kind_nxt  = KIND_CMD1;
          cmd_byte0_nxt = CMD_DISP_CTRL;
          cmd_byte1_nxt = 8'h00;
        end
      end

      S_IDLE: begin
        // Scan wins when it is the only request or when display went last.
        if (scan_pending && (!i_Disp_Valid || last_grant == GRANT_DISP)) begin
          grant_scan     = 1'b1;
          last_grant_nxt = GRANT_SCAN;
          state_nxt      = S_SCAN;
          cmd_valid_nxt  = 1'b1;
          cmd_kind_nxt   = KIND_READ;
          cmd_byte0_nxt  = CMD_READ_KEYS;
          cmd_byte1_nxt  = 8'h00;
        end else if (i_Disp_Valid) begin
          disp_ready_nxt = 1'b1;
          addr_nxt       = i_Disp_Addr;
          data_nxt       = i_Disp_Data;
          last_grant_nxt = GRANT_DISP;
          state_nxt      = S_MODE;
          cmd_valid_nxt  = 1'b1;
          cmd_kind_nxt   = KIND_CMD1;
          cmd_byte0_nxt  = CMD_WRITE_FIX;
          cmd_byte1_nxt  = 8'h00;
        end
      end

      S_MODE, S_WRITE, S_SCAN: begin
        if (o_Cmd_Valid && i_Cmd_Ready) begin
          cmd_valid_nxt = 1'b0;
          ret_state_nxt = (state == S_MODE) ? S_WRITE : S_IDLE;
          state_nxt     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (i_Cmd_Done) begin
          state_nxt = ret_state;
          if (o_Cmd_Kind == KIND_READ) begin
            keys_nxt       = i_Read_Data;
            keys_valid_nxt = 1'b1;
          end
          if (ret_state == S_WRITE) begin
            cmd_valid_nxt = 1'b1;
            cmd_kind_nxt  = KIND_CMD2;
            cmd_byte0_nxt = {4'hC, addr_q};
            cmd_byte1_nxt = data_q;
          end
        end
      end

      default: state_nxt = S_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state        <= S_INIT;
      ret_state    <= S_IDLE;
      last_grant   <= GRANT_SCAN;
      addr_q       <= '0;
      data_q       <= '0;
      o_Cmd_Valid  <= 1'b0;
      o_Cmd_Kind   <= KIND_CMD1;
      o_Cmd_Byte0  <= '0;
      o_Cmd_Byte1  <= '0;
      o_Disp_Ready <= 1'b0;
      o_Keys       <= '0;
      o_Keys_Valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      ret_state    <= ret_state_nxt;
      last_grant   <= last_grant_nxt;
      addr_q       <= addr_nxt;
      data_q       <= data_nxt;
      o_Cmd_Valid  <= cmd_valid_nxt;
      o_Cmd_Kind   <= cmd_kind_nxt;
      o_Cmd_Byte0  <= cmd_byte0_nxt;
      o_Cmd_Byte1  <= cmd_byte1_nxt;
      o_Disp_Ready <= disp_ready_nxt;
      o_Keys       <= keys_nxt;
      o_Keys_Valid <= keys_valid_nxt;
    end
  end

  // Clearing on grant takes priority: a wrap landing on the grant edge is a lost wrap.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      scan_cnt     <= '0;
      scan_pending <= 1'b0;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
      if (grant_scan)
        scan_pending <= 1'b0;
      else if (scan_wrap)
        scan_pending <= 1'b1;
    end
  end

`ifdef TM1638_CMD_SCHEDULER_DIAG_EN
  logic [7:0] overruns;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst)
      overruns <= '0;
    else if (scan_wrap && scan_pending && overruns != 8'hFF)
      overruns <= overruns + 8'd1;
  end

  assign o_Diag_State         = state;
  assign o_Diag_Scan_Overruns = overruns;
`endif

endmodule

// File: tb/tb_tm1638_cmd_scheduler.sv
// Randomized bench for tm1638_cmd_scheduler against a transaction-queue reference model.
module tb_tm1638_cmd_scheduler;

  localparam int unsigned PERIOD = 20;

  logic        i_Clk = 1'b0;
  logic        i_Rst;
  logic        i_Disp_Valid;
  logic [3:0]  i_Disp_Addr;
  logic [7:0]  i_Disp_Data;
  logic        o_Disp_Ready;
  logic        o_Cmd_Valid;
  logic [1:0]  o_Cmd_Kind;
  logic [7:0]  o_Cmd_Byte0;
  logic [7:0]  o_Cmd_Byte1;
  logic        i_Cmd_Ready;
  logic        i_Cmd_Done;
  logic [31:0] i_Read_Data;
  logic [31:0] o_Keys;
  logic        o_Keys_Valid;
`ifdef TM1638_CMD_SCHEDULER_DIAG_EN
  logic [2:0]  o_Diag_State;
  logic [7:0]  o_Diag_Scan_Overruns;
`endif

  tm1638_cmd_scheduler #(
    .SCAN_PERIOD_CYCLES(PERIOD),
    .BRIGHTNESS(7),
    .READ_WIDTH(32)
  ) dut (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_Disp_Valid(i_Disp_Valid),
    .i_Disp_Addr(i_Disp_Addr),
    .i_Disp_Data(i_Disp_Data),
    .o_Disp_Ready(o_Disp_Ready),
    .o_Cmd_Valid(o_Cmd_Valid),
    .o_Cmd_Kind(o_Cmd_Kind),
    .o_Cmd_Byte0(o_Cmd_Byte0),
    .o_Cmd_Byte1(o_Cmd_Byte1),
    .i_Cmd_Ready(i_Cmd_Ready),
    .i_Cmd_Done(i_Cmd_Done),
    .i_Read_Data(i_Read_Data),
    .o_Keys(o_Keys),
    .o_Keys_Valid(o_Keys_Valid)
`ifdef TM1638_CMD_SCHEDULER_DIAG_EN
    ,
    .o_Diag_State(o_Diag_State),
    .o_Diag_Scan_Overruns(o_Diag_Scan_Overruns)
`endif
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    logic [1:0] kind;
    logic [7:0] b0;
    logic [7:0] b1;
  } cmd_t;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: each granted request expands into a queue of commands.
  cmd_t        q[$];
  int unsigned m_edges;
  bit          m_pending, m_last_scan, m_start, m_offer, m_wait, m_scan_seq;
  bit          e_disp_ready, e_keys_valid;
  logic [31:0] e_keys;
  int          done_cnt;
  int          disp_pct, ready_pct;
  bit          spur_en;
  int          seen_keys, seen_disp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    q.push_back('{kind: 2'd0, b0: 8'h8F, b1: 8'h00});
    m_edges      = 0;
    m_pending    = 0;
    m_last_scan  = 1;
    m_start      = 1;
    m_offer      = 0;
    m_wait       = 0;
    m_scan_seq   = 0;
    e_disp_ready = 0;
    e_keys_valid = 0;
    e_keys       = '0;
    done_cnt     = 0;
  endtask

  task automatic model_edge();
    bit wrap, g_scan, g_disp;
    wrap   = ((m_edges % PERIOD) == PERIOD - 1);
    m_edges++;
    g_scan = 0;
    g_disp = 0;
    e_disp_ready = 0;
    e_keys_valid = 0;
    if (m_start) begin
      m_start = 0;
      m_offer = 1;
    end else if (m_offer) begin
      if (i_Cmd_Ready) begin
        m_offer  = 0;
        m_wait   = 1;
        done_cnt = $urandom_range(0, 3);
      end
    end else if (m_wait) begin
      if (i_Cmd_Done) begin
        m_wait = 0;
        void'(q.pop_front());
        if (m_scan_seq) begin
          e_keys       = i_Read_Data;
          e_keys_valid = 1;
          m_scan_seq   = 0;
        end
        if (q.size() > 0) m_offer = 1;
      end
    end else begin
      g_scan = (m_pending && i_Disp_Valid) ? !m_last_scan : m_pending;
      g_disp = i_Disp_Valid && !g_scan;
      if (g_scan) begin
        q.push_back('{kind: 2'd2, b0: 8'h42, b1: 8'h00});
        m_scan_seq  = 1;
        m_last_scan = 1;
        m_offer     = 1;
      end else if (g_disp) begin
        q.push_back('{kind: 2'd0, b0: 8'h44, b1: 8'h00});
        q.push_back('{kind: 2'd1, b0: 8'hC0 + 8'(i_Disp_Addr), b1: i_Disp_Data});
        e_disp_ready = 1;
        m_last_scan  = 0;
        m_offer      = 1;
      end
    end
    if (g_scan)    m_pending = 0;
    else if (wrap) m_pending = 1;
  endtask

  task automatic check_outputs();
    check("cmd_valid", o_Cmd_Valid, m_offer);
    if (m_offer && q.size() > 0) begin
      check("cmd_kind",  o_Cmd_Kind,  q[0].kind);
      check("cmd_byte0", o_Cmd_Byte0, q[0].b0);
      check("cmd_byte1", o_Cmd_Byte1, q[0].b1);
    end
    check("disp_ready", o_Disp_Ready, e_disp_ready);
    check("keys_valid", o_Keys_Valid, e_keys_valid);
    check("keys",       o_Keys,       e_keys);
    if (o_Keys_Valid) seen_keys++;
    if (o_Disp_Ready) seen_disp++;
  endtask

  // Called at a falling edge: drive inputs, advance the model over the next rising edge, check.
  task automatic cycle();
    if (e_disp_ready) i_Disp_Valid = 1'b0;
    if (!i_Disp_Valid && $urandom_range(0, 99) < disp_pct) begin
      i_Disp_Valid = 1'b1;
      i_Disp_Addr  = 4'($urandom);
      i_Disp_Data  = 8'($urandom);
    end
    i_Cmd_Ready = ($urandom_range(0, 99) < ready_pct);
    if (m_wait) begin
      if (done_cnt == 0) i_Cmd_Done = 1'b1;
      else begin
        i_Cmd_Done = 1'b0;
        done_cnt--;
      end
    end else begin
      i_Cmd_Done = spur_en && ($urandom_range(0, 7) == 0);
    end
    i_Read_Data = $urandom;
    model_edge();
    @(negedge i_Clk);
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},      o_Cmd_Valid,  1'b0);
    check({tag, "_kind"},       o_Cmd_Kind,   2'd0);
    check({tag, "_byte0"},      o_Cmd_Byte0,  8'h00);
    check({tag, "_byte1"},      o_Cmd_Byte1,  8'h00);
    check({tag, "_disp_ready"}, o_Disp_Ready, 1'b0);
    check({tag, "_keys"},       o_Keys,       32'h0);
    check({tag, "_keys_valid"}, o_Keys_Valid, 1'b0);
`ifdef TM1638_CMD_SCHEDULER_DIAG_EN
    check({tag, "_diag_state"},    o_Diag_State,         3'd0);
    check({tag, "_diag_overruns"}, o_Diag_Scan_Overruns, 8'd0);
`endif
  endtask

  task automatic run(input int n, input int dp, input int rp, input bit sp);
    disp_pct  = dp;
    ready_pct = rp;
    spur_en   = sp;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bit found;
    i_Rst        = 1'b1;
    i_Disp_Valid = 1'b0;
    i_Disp_Addr  = '0;
    i_Disp_Data  = '0;
    i_Cmd_Ready  = 1'b0;
    i_Cmd_Done   = 1'b0;
    i_Read_Data  = '0;
    seen_keys    = 0;
    seen_disp    = 0;
    repeat (3) @(negedge i_Clk);
    check_reset_values("reset");

    i_Rst = 1'b0;
    model_reset();
    run(60, 0, 100, 0);     // init command, then idle scans only
    run(400, 30, 70, 1);    // mixed traffic, back-pressure, spurious done
    run(300, 100, 90, 0);   // display always requesting: alternation with scans
    run(15, 100, 0, 1);     // engine stalled: offered command must hold
    run(40, 50, 80, 0);

    // Drive until the model sits waiting for the done of a CMD2 display write.
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (m_wait && q.size() == 1 && q[0].kind == 2'd1) found = 1;
      else cycle();
    end
    check("reach_write_wait", found, 1'b1);
    if (found) begin
      #2 i_Rst = 1'b1;
      #1 check_reset_values("async_rst");
      @(negedge i_Clk);
      i_Cmd_Done   = 1'b0;
      i_Disp_Valid = 1'b0;
      i_Rst        = 1'b0;
      model_reset();
      run(3, 0, 0, 0);      // brightness command must come back first and hold
      run(150, 40, 75, 1);
    end

    check("keys_seen", seen_keys > 0, 1'b1);
    check("disp_seen", seen_disp > 0, 1'b1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
